// File: rtl/rv32i_pkg.sv
// Shared RV32I core constants and types.
// Also provides the fetch FIFO entry layout and the word-alignment helper.
package rv32i_pkg;
    localparam int              XLEN      = 32;
    localparam int              INSTR_W   = 32;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;
    localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & {{(XLEN-2){1'b1}}, 2'b00};
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear and combinational head output.
// A push is accepted when full only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_clr,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_count = r_wptr - r_rptr;
    assign o_empty = (o_count == '0);
    assign w_full  = o_count[AW];
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!w_full || w_pop);
    assign o_data  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_clr) r_mem[r_wptr[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC, credit-limited imem requests, prefetch FIFO toward decode.
// Defining FETCH_PERF_EN adds the perf_fetched / perf_bubbles counters.
module fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instruction,
    output logic [XLEN-1:0]    pc_address
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_bubbles
`endif
);
    localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]     DEPTH_C = (CW+1)'(FIFO_DEPTH);

    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   r_drop;
    logic [CW-1:0]   w_live;
    logic [CW-1:0]   w_fifo_count;
    logic [CW:0]     w_live_drop;
    logic [CW:0]     w_live_fill;
    logic            w_q_empty;
    logic            w_fifo_empty;
    logic [XLEN-1:0] w_rsp_pc;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;
    logic            w_credit_ok;
    logic            w_accept;
    logic            w_rsp_keep;
    logic            w_rsp_drop;
    logic            w_pop;

    // The request-PC queue occupancy is exactly the live outstanding count.
    assign w_live_drop = {1'b0, w_live} + {1'b0, r_drop};
    assign w_live_fill = {1'b0, w_live} + {1'b0, w_fifo_count};
    assign w_credit_ok = (w_live_drop < DEPTH_C) && (w_live_fill < DEPTH_C);

    assign imem_req_valid = rst && !redirect_valid && w_credit_ok;
    assign imem_addr      = r_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;

    assign w_rsp_drop = imem_rsp_valid && (r_drop != '0);
    assign w_rsp_keep = imem_rsp_valid && (r_drop == '0) && !redirect_valid && !w_q_empty;

    assign instr_valid = !w_fifo_empty;
    assign w_pop       = instr_valid && instr_ready && !redirect_valid;
    assign instruction = instr_valid ? w_head.instr : '0;
    assign pc_address  = instr_valid ? w_head.pc    : '0;

    assign w_push_entry.pc    = w_rsp_pc;
    assign w_push_entry.instr = imem_rsp_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= align_word(redirect_pc);
        end else if (w_accept) begin
            r_pc <= r_pc + PC_STEP;
        end
    end

    // On redirect every outstanding request becomes wrong-path; a response
    // landing in that same cycle is one of them and is discarded now.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop <= '0;
        end else if (redirect_valid) begin
            r_drop <= r_drop + w_live - CW'(imem_rsp_valid);
        end else if (w_rsp_drop) begin
            r_drop <= r_drop - 1'b1;
        end
    end

    sync_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_req_pc_q (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_clr   (redirect_valid),
        .i_push  (w_accept),
        .i_data  (r_pc),
        .i_pop   (w_rsp_keep),
        .o_data  (w_rsp_pc),
        .o_empty (w_q_empty),
        .o_count (w_live)
    );

    sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_prefetch_q (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_clr   (redirect_valid),
        .i_push  (w_rsp_keep),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_bubbles;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_fetched <= '0;
            r_perf_bubbles <= '0;
        end else begin
            if (w_pop)                       r_perf_fetched <= r_perf_fetched + 1'b1;
            if (instr_ready && !instr_valid) r_perf_bubbles <= r_perf_bubbles + 1'b1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_bubbles = r_perf_bubbles;
`endif
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage feeding `decode` in the pipelined RV32I core. Holds the PC and issues word-aligned requests to instruction memory with a valid/ready handshake. Buffers in-order responses in a small prefetch FIFO and presents `instruction`/`pc_address` pairs to decode under a valid/ready handshake. Accepts PC redirects from the branch/jump resolution path and discards all wrong-path work.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset; must be word-aligned.
- `FIFO_DEPTH`, 4, prefetch FIFO entries; power of two, ≥2. It also caps outstanding memory requests.
- `clk`  in  1  core clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_addr`  out  32  request address; bits [1:0] are always 0.
- `imem_rsp_valid`  in  1  response data valid. Responses return in request order, at least 1 cycle after acceptance.
- `imem_rsp_data`  in  32  fetched instruction word.
- `redirect_valid`  in  1  one-cycle pulse: next_sel or branch taken.
- `redirect_pc`  in  32  target address; bits [1:0] are ignored and treated as 0.
- `instr_valid`  out  1  FIFO head valid toward decode.
- `instr_ready`  in  1  decode consumes the head this cycle.
- `instruction`  out  32  FIFO head instruction word.
- `pc_address`  out  32  PC of the head instruction.

## Operation
- Each FIFO entry holds {pc, instr}. A separate request-PC queue of `FIFO_DEPTH` entries holds the PC of every live outstanding request, so each response can be paired with its PC.
- **Counters:** `live` counts outstanding requests whose responses are kept. `drop` counts outstanding wrong-path requests whose responses are discarded.
- **Issue rule:** `imem_req_valid` = !redirect_valid && (live + drop < FIFO_DEPTH) && (live + fifo_count < FIFO_DEPTH).
  - `imem_req_valid` may fall without a handshake; memory must tolerate this.
- **On accept** (req_valid && req_ready):
  - push pc into the request-PC queue;
  - pc <= pc + 4, wrapping modulo 2^32;
  - live++.
- **On response:**
  - If drop > 0: drop--; the data is discarded.
  - Otherwise: live--; push {popped request-PC, rsp_data} into the FIFO.
  - The credit rule guarantees the FIFO never overflows.
- **Pop:** when instr_valid && instr_ready && !redirect_valid.
- **Redirect** (highest priority, same cycle as any other event):
  - FIFO and request-PC queue cleared;
  - drop <= drop + live − (1 if a drop-counted response arrives this cycle);
  - live <= 0;
  - pc <= {redirect_pc[31:2], 2'b00}.
  - A response arriving in the redirect cycle is always discarded.
  - No request is issued in the redirect cycle.
- Simultaneous push and pop in one cycle is allowed at any fill level, including full.

## Timing
- Reset values: pc = RESET_PC; live = 0; drop = 0; FIFO empty.
  - instr_valid = 0, imem_req_valid = 0, instruction = 0, pc_address = 0.
  - FETCH_PERF_EN counters = 0.
- First request: imem_req_valid rises in the first cycle after rst deasserts.
- Response-to-decode latency: a response at cycle N appears with instr_valid at N+1. There is no bypass.
- Redirect latency: redirect at N puts imem_addr = target with req_valid at N+1. With a 1-cycle memory, instr_valid for the target is at N+3.
- Throughput: one instruction per cycle when memory accepts every cycle, latency ≤ FIFO_DEPTH − 1, and decode never stalls.
- Reset asserted mid-operation returns all state to reset values immediately. Responses to earlier requests arriving after reset are a system error; the memory is reset together with this block.

## Configuration
- **`FETCH_PERF_EN` defined:** adds two outputs.
  - `perf_fetched` (out, 32): increments per pop.
  - `perf_bubbles` (out, 32): increments each cycle with instr_ready && !instr_valid.
  - Both wrap modulo 2^32.
- **Undefined:** neither port nor any counter logic exists.

## Structure
- Shared package `rv32i_pkg`: `XLEN` = 32, `INSTR_W` = 32, `PC_STEP` = 4, `NOP_INSTR` = 32'h0000_0013.
- One sub-module, `sync_fifo` (parameters WIDTH and DEPTH, with a clear input). It is instantiated twice: the {pc, instr} FIFO with WIDTH 64, and the request-PC queue with WIDTH 32.

## Test plan
- Reset release with memory always ready, 1-cycle latency, decode always ready → pc_address sequence 0x0, 0x4, 0x8… with instr_valid continuous from the 3rd cycle after reset.
- Decode holds instr_ready = 0 for 10 cycles → at most 4 requests are issued; no further req_valid; no data loss; the in-order sequence resumes after release.
- Three requests outstanding on a 3-cycle-latency memory, then redirect to 0x100 → the three responses are dropped and the next instr_valid has pc_address = 0x100.
- Redirect in the same cycle as a response and a decode pop → FIFO empty next cycle, that response is discarded, and the next request address is the target.
- Fetch from pc 0xFFFF_FFFC → the next request is at 0x0000_0000.
- redirect_pc = 0x203 → imem_addr = 0x200. With FETCH_PERF_EN, perf_fetched equals the count of handshakes.
